sbinit_sequencer: RTL and testbench
===================================

# sbinit_sequencer

Sideband initialization sequencer for the LTSM SBINIT state. Drives the link-partner handshake: repeated SBINIT out-of-reset, then the done_req / done_resp exchange. It emits sideband message code/subcode pairs to the sideband TX packetizer over a valid/ready handshake. It consumes decoded code/subcode pairs from the sideband RX path and encodes and decodes them through the SB_codex_pkg functions. On completion it reports done or error to the top-level LTSM.

## Interface
- RESEND_INTERVAL, 64: idle cycles between an accepted out_of_reset message and its next re-send; legal range is 1 or more.
- TIMEOUT_CYCLES, 4096: cycles from entering SEND_OOR to a fatal timeout. Used only when SBINIT_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  level signal; LTSM requests SBINIT. Sampled only in IDLE.
- tx_valid  out  1  message offered to the packetizer.
- tx_ready  in  1  packetizer accepts; a transfer happens when tx_valid and tx_ready are both high.
- tx_msg_code  out  8  message code, from encode_SB_msg.
- tx_msg_subcode  out  8  message subcode.
- rx_valid  in  1  one-cycle strobe; a received message is present.
- rx_msg_code  in  8  received code.
- rx_msg_subcode  in  8  received subcode.
- sbinit_done  out  1  SBINIT completed; sticky.
- sbinit_error  out  1  SBINIT failed; sticky.
- state_o  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, SEND_OOR=1, DONE_XCHG=2, DONE=3, ERROR=4.
- Every rx message is decoded with decode_SB_msg. A result of CODEX_ERROR is ignored in every state. rx_valid is ignored in IDLE, DONE and ERROR.
- IDLE -> SEND_OOR when start is high.
- SEND_OOR:
  - Offer out_of_reset (0x91/0x00).
  - After it is accepted, hold tx_valid low for RESEND_INTERVAL cycles, then offer it again. Repeat indefinitely.
  - A received out_of_reset sets oor_seen.
  - A received done_req sets both oor_seen and rx_req_seen.
  - A received done_resp is ignored.
  - Go to DONE_XCHG on the first cycle where oor_seen is set and either tx_valid is low or a transfer is completing.
- DONE_XCHG:
  - A received done_req sets rx_req_seen and resp_pending.
  - A received done_resp sets rx_resp_seen.
  - TX arbitration: done_resp (0x9A/0x01) has priority whenever resp_pending is set and tx_valid is low. Otherwise offer done_req (0x95/0x01), once only, until it is accepted (this sets req_sent).
  - Acceptance of done_resp clears resp_pending and sets resp_sent.
  - A duplicate done_req received after resp_sent queues one more done_resp.
  - Go to DONE when req_sent, rx_resp_seen and resp_sent are all set, and tx_valid is low.
- DONE: sbinit_done=1 and tx_valid=0, held until rst. start is ignored.
- ERROR: sbinit_error=1 and tx_valid=0, held until rst.
- Handshake rule: once tx_valid is high, tx_msg_code, tx_msg_subcode and tx_valid stay stable until the transfer. The only exceptions are entry to ERROR and rst, which are allowed aborts.
- All flags clear on rst and on entry to SEND_OOR.

## Timing
- Reset values: tx_valid=0, tx_msg_code=0x00, tx_msg_subcode=0x00, sbinit_done=0, sbinit_error=0, state_o=0. All internal flags and counters are 0.
- All outputs are registered; there is no combinational path from an input to an output.
- start sampled high at edge N -> state_o=1 and tx_valid=1 carrying 0x91/0x00 after edge N.
- Transfer at edge N -> tx_valid=0 after edge N. The next out_of_reset has tx_valid=1 after edge N+RESEND_INTERVAL.
- rx strobe at edge N -> the corresponding flag is set after edge N. A state change or new tx_valid takes effect no earlier than after edge N+1.
- A transfer and an rx strobe in the same cycle are both honoured.
- rst high at any edge, including mid-transfer, returns the block to reset values after that edge.

## Configuration
- SBINIT_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to SEND_OOR and increments every cycle in SEND_OOR and DONE_XCHG.
  - When the counter reaches TIMEOUT_CYCLES-1 without entering DONE, the block goes to ERROR on the next edge.
  - If completion and timeout fall on the same edge, DONE wins.
- SBINIT_TIMEOUT_EN undefined: there is no counter, ERROR is unreachable, and sbinit_error is tied to 0.

## Test plan
- tx_ready=1, no rx, RESEND_INTERVAL=64 -> out_of_reset (0x91/0x00) is accepted every 65 cycles; state_o stays 1.
- Hold tx_ready=0 for 10 cycles, then raise it -> tx_valid and code stay stable throughout, with exactly one transfer.
- Inject partner out_of_reset, then done_req and done_resp, with tx_ready=1 -> block sends done_req then done_resp. sbinit_done=1 after the last acceptance; state_o=3.
- Inject partner done_req while our done_req is pending and tx_ready=0 -> once ready rises, both messages are transferred in order: first 0x95/0x01, then 0x9A/0x01.
- Inject rx 0x55/0x77 in SEND_OOR -> no state change and no flag set.
- With SBINIT_TIMEOUT_EN and TIMEOUT_CYCLES=100, no partner -> sbinit_error=1 and tx_valid=0 at cycle 100. Then assert rst -> all outputs return to 0.

Source files
------------

// File: rtl/sbinit_sequencer.sv
// SBINIT sideband sequencer: out_of_reset resend loop, then done_req/done_resp exchange.
// Define SBINIT_TIMEOUT_EN to enable the fatal timeout counter and the ERROR state.
package SB_codex_pkg;
  typedef enum logic [1:0] {
    CODEX_ERROR,
    SB_OOR,
    SB_DONE_REQ,
    SB_DONE_RESP
  } sb_msg_e;

  function automatic logic [15:0] encode_SB_msg(input sb_msg_e m);
    logic [15:0] r;
    r = 16'h0000;
    unique case (m)
      SB_OOR:       r = 16'h9100;
      SB_DONE_REQ:  r = 16'h9501;
      SB_DONE_RESP: r = 16'h9A01;
      default:      r = 16'h0000;
    endcase
    return r;
  endfunction

  function automatic sb_msg_e decode_SB_msg(
    input logic [7:0] code,
    input logic [7:0] sub
  );
    sb_msg_e m;
    m = CODEX_ERROR;
    unique case (1'b1)
      ({code, sub} == 16'h9100): m = SB_OOR;
      ({code, sub} == 16'h9501): m = SB_DONE_REQ;
      ({code, sub} == 16'h9A01): m = SB_DONE_RESP;
      default:                   m = CODEX_ERROR;
    endcase
    return m;
  endfunction
endpackage

module sbinit_sequencer
  import SB_codex_pkg::*;
#(
  parameter int unsigned RESEND_INTERVAL = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_msg_code,
  output logic [7:0] tx_msg_subcode,
  input  logic       rx_valid,
  input  logic [7:0] rx_msg_code,
  input  logic [7:0] rx_msg_subcode,
  output logic       sbinit_done,
  output logic       sbinit_error,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_OOR  = 3'd1,
    DONE_XCHG = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } state_e;

  localparam int GAP_W =
    (RESEND_INTERVAL > 1) ? $clog2(RESEND_INTERVAL) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX =
    GAP_W'(RESEND_INTERVAL - 1);

  if (RESEND_INTERVAL < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("sbinit_sequencer: illegal parameter value");
  end

  state_e           state_q, state_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       sub_q, sub_d;
  logic             done_q, done_d;
  logic             oor_seen_q, oor_seen_d;
  logic             rx_req_seen_q, rx_req_seen_d;
  logic             rx_resp_seen_q, rx_resp_seen_d;
  logic             resp_pend_q, resp_pend_d;
  logic             req_sent_q, req_sent_d;
  logic             resp_sent_q, resp_sent_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  sb_msg_e          rx_msg;
  logic             xfer;
`ifdef SBINIT_TIMEOUT_EN
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d        = state_q;
    tx_valid_d     = tx_valid_q;
    code_d         = code_q;
    sub_d          = sub_q;
    done_d         = done_q;
    oor_seen_d     = oor_seen_q;
    rx_req_seen_d  = rx_req_seen_q;
    rx_resp_seen_d = rx_resp_seen_q;
    resp_pend_d    = resp_pend_q;
    req_sent_d     = req_sent_q;
    resp_sent_d    = resp_sent_q;
    gap_d          = gap_q;
    rx_msg = rx_valid ? decode_SB_msg(rx_msg_code, rx_msg_subcode)
                      : CODEX_ERROR;
    xfer   = tx_valid_q & tx_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = SEND_OOR;
          oor_seen_d     = 1'b0;
          rx_req_seen_d  = 1'b0;
          rx_resp_seen_d = 1'b0;
          resp_pend_d    = 1'b0;
          req_sent_d     = 1'b0;
          resp_sent_d    = 1'b0;
          gap_d          = '0;
          tx_valid_d     = 1'b1;
          {code_d, sub_d} = encode_SB_msg(SB_OOR);
        end
      end
      SEND_OOR: begin
        if (rx_msg == SB_OOR) oor_seen_d = 1'b1;
        if (rx_msg == SB_DONE_REQ) begin
          oor_seen_d    = 1'b1;
          rx_req_seen_d = 1'b1;
        end
        // Leave only with no offer outstanding, so the handshake is never broken
        if (oor_seen_q && (!tx_valid_q || xfer)) begin
          state_d    = DONE_XCHG;
          tx_valid_d = 1'b0;
        end else if (xfer) begin
          tx_valid_d = 1'b0;
          gap_d      = '0;
        end else if (!tx_valid_q) begin
          if (gap_q == GAP_MAX) begin
            tx_valid_d = 1'b1;
            {code_d, sub_d} = encode_SB_msg(SB_OOR);
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      DONE_XCHG: begin
        if (req_sent_q && rx_resp_seen_q && resp_sent_q && !tx_valid_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (xfer) begin
          tx_valid_d = 1'b0;
          if ({code_q, sub_q} == encode_SB_msg(SB_DONE_RESP)) begin
            resp_pend_d = 1'b0;
            resp_sent_d = 1'b1;
          end else begin
            req_sent_d = 1'b1;
          end
        end else if (!tx_valid_q) begin
          if (resp_pend_q) begin
            tx_valid_d = 1'b1;
            {code_d, sub_d} = encode_SB_msg(SB_DONE_RESP);
          end else if (!req_sent_q) begin
            tx_valid_d = 1'b1;
            {code_d, sub_d} = encode_SB_msg(SB_DONE_REQ);
          end
        end
        // A request landing with a resp acceptance re-arms the pending resp
        if (rx_msg == SB_DONE_REQ) begin
          rx_req_seen_d = 1'b1;
          resp_pend_d   = 1'b1;
        end
        if (rx_msg == SB_DONE_RESP) rx_resp_seen_d = 1'b1;
      end
      DONE, ERROR: ;
      default: ;
    endcase

`ifdef SBINIT_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    if (state_q == IDLE && start) begin
      to_cnt_d = '0;
    end else if (state_q == SEND_OOR || state_q == DONE_XCHG) begin
      to_cnt_d = to_cnt_q + 16'd1;
      if (state_d != DONE && to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        state_d    = ERROR;
        tx_valid_d = 1'b0;
        err_d      = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tx_valid_q     <= 1'b0;
      code_q         <= 8'h00;
      sub_q          <= 8'h00;
      done_q         <= 1'b0;
      oor_seen_q     <= 1'b0;
      rx_req_seen_q  <= 1'b0;
      rx_resp_seen_q <= 1'b0;
      resp_pend_q    <= 1'b0;
      req_sent_q     <= 1'b0;
      resp_sent_q    <= 1'b0;
      gap_q          <= '0;
`ifdef SBINIT_TIMEOUT_EN
      to_cnt_q       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      tx_valid_q     <= tx_valid_d;
      code_q         <= code_d;
      sub_q          <= sub_d;
      done_q         <= done_d;
      oor_seen_q     <= oor_seen_d;
      rx_req_seen_q  <= rx_req_seen_d;
      rx_resp_seen_q <= rx_resp_seen_d;
      resp_pend_q    <= resp_pend_d;
      req_sent_q     <= req_sent_d;
      resp_sent_q    <= resp_sent_d;
      gap_q          <= gap_d;
`ifdef SBINIT_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign tx_valid       = tx_valid_q;
  assign tx_msg_code    = code_q;
  assign tx_msg_subcode = sub_q;
  assign sbinit_done    = done_q;
  assign state_o        = state_q;
`ifdef SBINIT_TIMEOUT_EN
  assign sbinit_error   = err_q;
`else
  assign sbinit_error   = 1'b0;
`endif

endmodule

// File: tb/tb_sbinit_sequencer.sv
// Scoreboard bench for sbinit_sequencer: random stimulus vs. a rule-level model.
`timescale 1ns/1ps
module tb_sbinit_sequencer;
  localparam int RI = 64;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst, start, tx_ready, rx_valid;
  logic [7:0] rx_msg_code, rx_msg_subcode;
  logic       tx_valid, sbinit_done, sbinit_error;
  logic [7:0] tx_msg_code, tx_msg_subcode;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  sbinit_sequencer #(.RESEND_INTERVAL(RI), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_msg_code(tx_msg_code), .tx_msg_subcode(tx_msg_subcode),
    .rx_valid(rx_valid), .rx_msg_code(rx_msg_code),
    .rx_msg_subcode(rx_msg_subcode),
    .sbinit_done(sbinit_done), .sbinit_error(sbinit_error),
    .state_o(state_o)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] xfer_log[$];
  int          xfer_cyc[$];

  // Model: state number, current offer, rule flags, absolute event times
  int cyc = 0;
  int m_state, m_resend_at, m_deadline;
  bit m_valid, m_oor, m_reqseen, m_respseen, m_pend;
  bit m_reqsent, m_respsent, m_done, m_err;
  logic [7:0] m_code, m_sub;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d",
               name, act, req, cyc);
    end
  endtask

  function automatic int kind(logic [7:0] c, logic [7:0] s);
    if (c == 8'h91 && s == 8'h00) return 1;
    if (c == 8'h95 && s == 8'h01) return 2;
    if (c == 8'h9A && s == 8'h01) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_valid = 0; m_code = 0; m_sub = 0;
    m_oor = 0; m_reqseen = 0; m_respseen = 0; m_pend = 0;
    m_reqsent = 0; m_respsent = 0; m_done = 0; m_err = 0;
    m_resend_at = -1; m_deadline = -1;
  endtask

  task automatic model_edge();
    bit xfer, go, fin;
    int k, old;
    cyc++;
    xfer = m_valid && tx_ready;
    k = rx_valid ? kind(rx_msg_code, rx_msg_subcode) : 0;
    old = m_state;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (start) begin
        m_oor = 0; m_reqseen = 0; m_respseen = 0; m_pend = 0;
        m_reqsent = 0; m_respsent = 0;
        m_state = 1; m_valid = 1; m_code = 8'h91; m_sub = 8'h00;
        m_deadline = cyc + TO;
      end
      1: begin
        go = m_oor && (!m_valid || xfer);
        if (k == 1 || k == 2) m_oor = 1;
        if (k == 2) m_reqseen = 1;
        if (go) begin
          m_state = 2; m_valid = 0;
        end else if (xfer) begin
          m_valid = 0; m_resend_at = cyc + RI;
        end else if (!m_valid && cyc == m_resend_at) begin
          m_valid = 1; m_code = 8'h91; m_sub = 8'h00;
        end
      end
      2: begin
        fin = m_reqsent && m_respseen && m_respsent && !m_valid;
        if (fin) begin
          m_state = 3; m_done = 1;
        end else if (xfer) begin
          m_valid = 0;
          if (m_code == 8'h95) m_reqsent = 1;
          else begin m_respsent = 1; m_pend = 0; end
        end else if (!m_valid) begin
          if (m_pend) begin
            m_valid = 1; m_code = 8'h9A; m_sub = 8'h01;
          end else if (!m_reqsent) begin
            m_valid = 1; m_code = 8'h95; m_sub = 8'h01;
          end
        end
        if (k == 2) begin m_reqseen = 1; m_pend = 1; end
        if (k == 3) m_respseen = 1;
      end
      default: ;
    endcase
`ifdef SBINIT_TIMEOUT_EN
    if ((old == 1 || old == 2) && m_state != 3 && cyc == m_deadline) begin
      m_state = 4; m_valid = 0; m_err = 1;
    end
`endif
  endtask

  // Advance one edge, then apply the inputs for the coming cycle
  task automatic step(bit r, bit st, bit rdy, bit rv,
                      logic [7:0] c, logic [7:0] s);
    @(posedge clk);
    #1;
    model_edge();
    rst = r; start = st; tx_ready = rdy;
    rx_valid = rv; rx_msg_code = c; rx_msg_subcode = s;
    if (!r && m_valid && rdy) exp_q.push_back({m_code, m_sub});
  endtask

  task automatic idle(bit r, bit st, bit rdy);
    step(r, st, rdy, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic send_rx(int k, bit st, bit rdy);
    logic [7:0] c, s;
    case (k)
      1: begin c = 8'h91; s = 8'h00; end
      2: begin c = 8'h95; s = 8'h01; end
      3: begin c = 8'h9A; s = 8'h01; end
      default: begin
        c = 8'($urandom); s = 8'($urandom);
        if (kind(c, s) != 0) begin c = 8'h55; s = 8'h77; end
      end
    endcase
    step(1'b0, st, rdy, 1'b1, c, s);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    chk("state_o", 32'(state_o), 32'(m_state));
    chk("tx_valid", 32'(tx_valid), 32'(m_valid));
    chk("sbinit_done", 32'(sbinit_done), 32'(m_done));
    chk("sbinit_error", 32'(sbinit_error), 32'(m_err));
    if (m_valid)
      chk("tx_msg", {16'h0, tx_msg_code, tx_msg_subcode}, {16'h0, m_code, m_sub});
    if (tx_valid && tx_ready && !rst) begin
      xfer_log.push_back({tx_msg_code, tx_msg_subcode});
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL xfer_unexpected actual=%02h/%02h required=none cycle=%0d",
                 tx_msg_code, tx_msg_subcode, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_msg", {16'h0, tx_msg_code, tx_msg_subcode}, {16'h0, e});
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_code"}, {16'h0, tx_msg_code, tx_msg_subcode}, 0);
    chk({tag, "_done"}, 32'(sbinit_done), 0);
    chk({tag, "_error"}, 32'(sbinit_error), 0);
    chk({tag, "_state"}, 32'(state_o), 0);
  endtask

  initial begin
    int n, base;
    model_reset();
    rst = 1; start = 0; tx_ready = 0;
    rx_valid = 0; rx_msg_code = 0; rx_msg_subcode = 0;
    idle(1, 0, 0);
    idle(0, 0, 1);
    check_reset_outputs("reset");

    // Free-running out_of_reset resend with the packetizer always ready
    xfer_cyc.delete();
    idle(0, 1, 1);
    repeat (300) idle(0, 0, 1);
    chk("oor_xfer_count_ge2", 32'(xfer_cyc.size() >= 2), 1);
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk("oor_period", 32'(xfer_cyc[i] - xfer_cyc[i-1]), RI + 1);

    // Stall, rx garbage, then the full exchange with crossed done_req
    idle(1, 0, 0);
    idle(0, 1, 0);
    repeat (10) idle(0, 0, 0);
    base = xfer_log.size();
    idle(0, 0, 1);
    idle(0, 0, 1);
    chk("stall_one_xfer", 32'(xfer_log.size() - base), 1);
    repeat (3) step(0, 0, 0, 1, 8'h55, 8'h77);
    repeat (3) idle(0, 0, 0);
    @(negedge clk);
    chk("garbage_state", 32'(state_o), 1);
    send_rx(1, 0, 1);
    n = 0;
    while (!(m_state == 2 && m_valid) && n < 200) begin
      idle(0, 0, 0); n++;
    end
    chk("reach_xchg_offer", 32'(n < 200), 1);
    send_rx(2, 0, 0);
    repeat (10) idle(0, 0, 0);
    base = xfer_log.size();
    repeat (8) idle(0, 0, 1);
    chk("xchg_xfer_count", 32'(xfer_log.size() - base), 2);
    if (xfer_log.size() - base >= 2) begin
      chk("xchg_first", 32'(xfer_log[base]), 32'h9501);
      chk("xchg_second", 32'(xfer_log[base+1]), 32'h9A01);
    end
    send_rx(3, 0, 1);
    repeat (5) idle(0, 1, 1);
    @(negedge clk);
    chk("done_flag", 32'(sbinit_done), 1);
    chk("done_state", 32'(state_o), 3);

`ifdef SBINIT_TIMEOUT_EN
    begin
      int t_enter;
      t_enter = -1;
      idle(1, 0, 0);
      idle(0, 1, 1);
      n = 0;
      while (!sbinit_error && n < 300) begin
        idle(0, 0, $urandom_range(0, 1));
        @(negedge clk);
        if (state_o == 3'd1 && t_enter < 0) t_enter = cyc;
        n++;
      end
      chk("timeout_cycles", 32'(cyc - t_enter), TO);
      chk("timeout_tx_valid", 32'(tx_valid), 0);
      idle(1, 0, 0);
      idle(0, 0, 0);
      check_reset_outputs("post_timeout_rst");
    end
`endif

    // Randomized episodes with varied ready behaviour and partner traffic
    for (int ep = 0; ep < 12; ep++) begin
      int rmode, hold;
      bit rdy, r;
      rmode = ep % 3;
      hold = 0;
      idle(1, 0, 0);
      for (int c = 0; c < 3000 && hold < 5; c++) begin
        case (rmode)
          0: rdy = 1;
          1: rdy = 1'($urandom_range(0, 1));
          default: rdy = ($urandom_range(0, 9) != 0);
        endcase
        r = ($urandom_range(0, 699) == 0);
        if (m_state == 3 || m_state == 4) hold++;
        if (!r && m_state == 1 && $urandom_range(0, 24) == 0)
          send_rx($urandom_range(0, 3), 1'($urandom_range(0, 1)), rdy);
        else if (!r && m_state == 2 && $urandom_range(0, 11) == 0)
          send_rx($urandom_range(0, 9) < 4 ? 2 : $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), rdy);
        else
          idle(r, 1'($urandom_range(0, 3) != 0), rdy);
      end
    end

    idle(1, 0, 1);
    idle(0, 0, 1);
    check_reset_outputs("final_reset");
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
